mem_stage_ctrl: RTL and testbench

//  Stage-2/3 boundary of the data memory path, beside the write-mask/shift logic. Decodes the

---
 rtl/mem_stage_ctrl_pkg.sv | 31 +++
 rtl/mem_stage_ctrl_load_extend.sv | 36 +++
 rtl/mem_stage_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared constants for the data-memory path: region nibbles, IO register
// offsets and the access-size encoding also used by the write-mask/shift logic.
package mem_stage_ctrl_pkg;

   // Address[31:28] values that select each memory region
   localparam logic [3:0] DMEM_REGION = 4'h1;
   localparam logic [3:0] IMEM_REGION = 4'h2;
   localparam logic [3:0] IO_REGION   = 4'h8;

   // IO register offsets on Address[7:0]
   localparam logic [7:0] IO_UART_STATUS = 8'h00;
   localparam logic [7:0] IO_UART_RX     = 8'h04;
   localparam logic [7:0] IO_UART_TX     = 8'h08;
   localparam logic [7:0] IO_CYCLE       = 8'h10;
   localparam logic [7:0] IO_INSTRET     = 8'h14;
   localparam logic [7:0] IO_CNT_CLEAR   = 8'h18;

   // Access size; both 1x encodings mean a full word
   typedef enum logic [1:0] {
      MEM_BYTE     = 2'b00,
      MEM_HALF     = 2'b01,
      MEM_WORD     = 2'b10,
      MEM_WORD_ALT = 2'b11
   } memSize_e;

   // True for either word encoding
   function automatic logic isWordSize(input memSize_e size);
      return size[1];
   endfunction

endpackage

// File: rtl/mem_stage_ctrl_load_extend.sv
// Stage-3 load alignment: picks the addressed big-endian byte or half out of
// the 32-bit read word and sign- or zero-extends it. Words pass unchanged.
module load_extend
   import mem_stage_ctrl_pkg::*;
(
   input  logic [31:0] i_data,
   input  logic [1:0]  i_offset,
   input  memSize_e    i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane select (byte 0 is the most significant lane), then extension by size
   always_comb begin
      w_byte = i_data[7:0];
      case (i_offset)
         2'd0:    w_byte = i_data[31:24];
         2'd1:    w_byte = i_data[23:16];
         2'd2:    w_byte = i_data[15:8];
         default: w_byte = i_data[7:0];
      endcase
      w_half   = i_offset[1] ? i_data[15:0] : i_data[31:16];
      o_result = i_data;
      if (!isWordSize(i_size)) begin
         if (i_size == MEM_BYTE) begin
            o_result = {{24{~i_unsigned & w_byte[7]}}, w_byte};
         end else begin
            o_result = {{16{~i_unsigned & w_half[15]}}, w_half};
         end
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Stage-2/3 boundary of the data-memory path. Decodes the stage-2 address
// into DMEM/IMEM/IO, gates write masks per region, carries load metadata over
// the BRAM read latency, and owns the memory-mapped UART and counters.
module mem_stage_ctrl
   import mem_stage_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic [3:0]  WriteMaskIn,
   input  logic [1:0]  MemSize,
   input  logic        LoadUnsigned,
   input  logic        ReadEnable,
   input  logic        WriteEnable,
   input  logic        Stall,
   input  logic        InstRetired,
   input  logic [31:0] DmemDout,
   input  logic [7:0]  UartRxData,
   input  logic        UartRxValid,
   input  logic        UartTxReady,
   output logic [3:0]  DmemWriteMask,
   output logic [3:0]  ImemWriteMask,
   output logic        UartRxReady,
   output logic [7:0]  UartTxData,
   output logic        UartTxValid,
   output logic [31:0] LoadData
);

   logic        w_isDmem;
   logic        w_isImem;
   logic        w_isIo;
   logic [7:0]  w_ioOffset;
   logic [31:0] w_ioRdata;
   logic        w_txStore;
   logic        w_clearStore;
   logic [31:0] w_loadSource;
   logic [31:0] w_extended;
   logic [31:0] w_liveLoad;
   logic        w_unused;

   logic [1:0]  r_s3Offset;
   memSize_e    r_s3Size;
   logic        r_s3Unsigned;
   logic        r_s3IsIo;
   logic        r_s3IsLoad;
   logic [31:0] r_s3IoRdata;
   logic [31:0] r_cycleCount;
   logic [31:0] r_instretCount;
   logic [7:0]  r_txData;
   logic        r_txValid;
   logic [31:0] r_holdData;
   logic        r_holdValid;

   assign w_isDmem   = (Address[31:28] == DMEM_REGION);
   assign w_isImem   = (Address[31:28] == IMEM_REGION);
   assign w_isIo     = (Address[31:28] == IO_REGION);
   assign w_ioOffset = Address[7:0];

   assign DmemWriteMask = w_isDmem ? WriteMaskIn : 4'b0000;
   assign ImemWriteMask = w_isImem ? WriteMaskIn : 4'b0000;

   // Stalled cycles must not pop the rx FIFO, strobe tx or clear counters
   assign UartRxReady  = ReadEnable & w_isIo & (w_ioOffset == IO_UART_RX) & ~Stall;
   assign w_txStore    = WriteEnable & w_isIo & (w_ioOffset == IO_UART_TX) & ~Stall;
   assign w_clearStore = WriteEnable & w_isIo & (w_ioOffset == IO_CNT_CLEAR) & ~Stall;

   assign w_unused = ^{Address[27:8], WriteData[31:8]};

   // IO read mux; counters are sampled before this edge's increment
   always_comb begin
      w_ioRdata = 32'h0;
      case (w_ioOffset)
         IO_UART_STATUS: w_ioRdata = {30'b0, UartRxValid, UartTxReady};
         IO_UART_RX:     w_ioRdata = {24'b0, UartRxData};
         IO_CYCLE:       w_ioRdata = r_cycleCount;
         IO_INSTRET:     w_ioRdata = r_instretCount;
         default:        w_ioRdata = 32'h0;
      endcase
   end

   // Stage-2 to stage-3 register: load metadata frozen while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s3Offset   <= 2'b00;
         r_s3Size     <= MEM_BYTE;
         r_s3Unsigned <= 1'b0;
         r_s3IsIo     <= 1'b0;
         r_s3IsLoad   <= 1'b0;
         r_s3IoRdata  <= 32'h0;
      end else if (!Stall) begin
         r_s3Offset   <= Address[1:0];
         r_s3Size     <= memSize_e'(MemSize);
         r_s3Unsigned <= LoadUnsigned;
         r_s3IsIo     <= w_isIo;
         r_s3IsLoad   <= ReadEnable;
         r_s3IoRdata  <= w_ioRdata;
      end
   end

   // Free-running cycle counter and retired-instruction counter; a clear store wins
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cycleCount   <= 32'h0;
         r_instretCount <= 32'h0;
      end else if (w_clearStore) begin
         r_cycleCount   <= 32'h0;
         r_instretCount <= 32'h0;
      end else begin
         r_cycleCount <= r_cycleCount + 32'd1;
         if (InstRetired) begin
            r_instretCount <= r_instretCount + 32'd1;
         end
      end
   end

   // UART transmit: one-cycle strobe per accepted store, byte dropped when not ready
   always_ff @(posedge clk) begin
      if (rst) begin
         r_txData  <= 8'h00;
         r_txValid <= 1'b0;
      end else begin
         r_txValid <= w_txStore & UartTxReady;
         if (w_txStore && UartTxReady) begin
            r_txData <= WriteData[7:0];
         end
      end
   end

   assign UartTxData  = r_txData;
   assign UartTxValid = r_txValid;

   assign w_loadSource = r_s3IsIo ? r_s3IoRdata : DmemDout;

   load_extend u_loadExtend (
      .i_data     (w_loadSource),
      .i_offset   (r_s3Offset),
      .i_size     (r_s3Size),
      .i_unsigned (r_s3Unsigned),
      .o_result   (w_extended)
   );

   assign w_liveLoad = r_s3IsLoad ? w_extended : 32'h0;

   // Capture the result on the first stalled cycle since BRAM output may drift afterwards
   always_ff @(posedge clk) begin
      if (rst) begin
         r_holdData  <= 32'h0;
         r_holdValid <= 1'b0;
      end else if (Stall) begin
         if (!r_holdValid) begin
            r_holdData  <= w_liveLoad;
            r_holdValid <= 1'b1;
         end
      end else begin
         r_holdValid <= 1'b0;
      end
   end

   assign LoadData = (Stall && r_holdValid) ? r_holdData : w_liveLoad;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl: load alignment, region
// masks, UART handshakes, counters and stall hold behaviour.
module tb_mem_stage_ctrl;
   import mem_stage_ctrl_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic [3:0]  WriteMaskIn;
   logic [1:0]  MemSize;
   logic        LoadUnsigned;
   logic        ReadEnable;
   logic        WriteEnable;
   logic        Stall;
   logic        InstRetired;
   logic [31:0] DmemDout;
   logic [7:0]  UartRxData;
   logic        UartRxValid;
   logic        UartTxReady;
   logic [3:0]  DmemWriteMask;
   logic [3:0]  ImemWriteMask;
   logic        UartRxReady;
   logic [7:0]  UartTxData;
   logic        UartTxValid;
   logic [31:0] LoadData;

   int checks;
   int errors;

   mem_stage_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .Address       (Address),
      .WriteData     (WriteData),
      .WriteMaskIn   (WriteMaskIn),
      .MemSize       (MemSize),
      .LoadUnsigned  (LoadUnsigned),
      .ReadEnable    (ReadEnable),
      .WriteEnable   (WriteEnable),
      .Stall         (Stall),
      .InstRetired   (InstRetired),
      .DmemDout      (DmemDout),
      .UartRxData    (UartRxData),
      .UartRxValid   (UartRxValid),
      .UartTxReady   (UartTxReady),
      .DmemWriteMask (DmemWriteMask),
      .ImemWriteMask (ImemWriteMask),
      .UartRxReady   (UartRxReady),
      .UartTxData    (UartTxData),
      .UartTxValid   (UartTxValid),
      .LoadData      (LoadData)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge so outputs are stable
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one stage-2 memory access
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] mask, input logic [1:0] size,
                                input logic uns, input logic re, input logic we);
      Address      = addr;
      WriteData    = wdata;
      WriteMaskIn  = mask;
      MemSize      = size;
      LoadUnsigned = uns;
      ReadEnable   = re;
      WriteEnable  = we;
      #1;
   endtask

   // Idle stage-2: no access
   task automatic idle();
      applyStimulus(32'h0, 32'h0, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0);
   endtask

   // One comparison, counted and reported on mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
      end
   endtask

   // Directed test sequence
   initial begin
      logic [31:0] expSigned [4];
      logic [31:0] expUnsigned [4];
      checks = 0;
      errors = 0;
      expSigned   = '{32'hFFFFFF80, 32'hFFFFFFFF, 32'h0000007F, 32'h00000001};
      expUnsigned = '{32'h00000080, 32'h000000FF, 32'h0000007F, 32'h00000001};

      rst = 1'b1; Stall = 1'b0; InstRetired = 1'b0; DmemDout = 32'h0;
      UartRxData = 8'h00; UartRxValid = 1'b0; UartTxReady = 1'b0;
      idle();
      tick();
      tick();
      checkOutput("reset_txvalid", {31'b0, UartTxValid}, 32'h0);
      checkOutput("reset_txdata", {24'b0, UartTxData}, 32'h0);
      checkOutput("reset_loaddata", LoadData, 32'h0);
      rst = 1'b0;

      // Byte loads at every offset, signed then unsigned
      DmemDout = 32'h80FF7F01;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(32'h1000_0000 | 32'(i), 32'h0, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
         tick();
         checkOutput($sformatf("lb_signed_%0d", i), LoadData, expSigned[i]);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(32'h1000_0000 | 32'(i), 32'h0, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0);
         tick();
         checkOutput($sformatf("lb_unsigned_%0d", i), LoadData, expUnsigned[i]);
      end

      // Half load then word load, one cycle latency
      DmemDout = 32'h1234_8000;
      applyStimulus(32'h1000_0002, 32'h0, 4'b0000, 2'b01, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("lh_signed", LoadData, 32'hFFFF8000);
      applyStimulus(32'h1000_0000, 32'h0, 4'b0000, 2'b10, 1'b0, 1'b1, 1'b0);
      checkOutput("lw_before_edge", LoadData, 32'hFFFF8000);
      tick();
      checkOutput("lw_after_edge", LoadData, 32'h12348000);

      // Region write-mask gating
      applyStimulus(32'h2000_0010, 32'hDEADBEEF, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b1);
      checkOutput("imem_mask_imem", {28'b0, ImemWriteMask}, 32'hF);
      checkOutput("imem_mask_dmem", {28'b0, DmemWriteMask}, 32'h0);
      applyStimulus(32'h1000_0010, 32'hDEADBEEF, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b1);
      checkOutput("dmem_mask_imem", {28'b0, ImemWriteMask}, 32'h0);
      checkOutput("dmem_mask_dmem", {28'b0, DmemWriteMask}, 32'hF);
      tick();

      // UART transmit with ready, without ready, and back-to-back
      UartTxReady = 1'b1;
      applyStimulus(32'h8000_0008, 32'h0000_0041, 4'b1000, 2'b00, 1'b0, 1'b0, 1'b1);
      checkOutput("io_mask_dmem", {28'b0, DmemWriteMask}, 32'h0);
      checkOutput("tx_valid_before", {31'b0, UartTxValid}, 32'h0);
      tick();
      idle();
      checkOutput("tx_valid_strobe", {31'b0, UartTxValid}, 32'h1);
      checkOutput("tx_data", {24'b0, UartTxData}, 32'h41);
      tick();
      checkOutput("tx_valid_one_cycle", {31'b0, UartTxValid}, 32'h0);
      UartTxReady = 1'b0;
      applyStimulus(32'h8000_0008, 32'h0000_0042, 4'b1000, 2'b00, 1'b0, 1'b0, 1'b1);
      tick();
      idle();
      checkOutput("tx_not_ready", {31'b0, UartTxValid}, 32'h0);
      UartTxReady = 1'b1;
      applyStimulus(32'h8000_0008, 32'h0000_0055, 4'b1000, 2'b00, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("tx_b2b_first_valid", {31'b0, UartTxValid}, 32'h1);
      checkOutput("tx_b2b_first_data", {24'b0, UartTxData}, 32'h55);
      applyStimulus(32'h8000_0008, 32'h0000_0066, 4'b1000, 2'b00, 1'b0, 1'b0, 1'b1);
      tick();
      idle();
      checkOutput("tx_b2b_second_valid", {31'b0, UartTxValid}, 32'h1);
      checkOutput("tx_b2b_second_data", {24'b0, UartTxData}, 32'h66);
      tick();
      checkOutput("tx_b2b_done", {31'b0, UartTxValid}, 32'h0);

      // UART receive pop, then the same load stalled
      UartRxValid = 1'b1;
      UartRxData  = 8'h5A;
      applyStimulus(32'h8000_0004, 32'h0, 4'b0000, 2'b10, 1'b0, 1'b1, 1'b0);
      checkOutput("rx_ready", {31'b0, UartRxReady}, 32'h1);
      tick();
      idle();
      checkOutput("rx_loaddata", LoadData, 32'h0000005A);
      Stall = 1'b1;
      applyStimulus(32'h8000_0004, 32'h0, 4'b0000, 2'b10, 1'b0, 1'b1, 1'b0);
      checkOutput("rx_ready_stalled", {31'b0, UartRxReady}, 32'h0);
      applyStimulus(32'h8000_0008, 32'h0000_0077, 4'b1000, 2'b00, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("tx_stalled", {31'b0, UartTxValid}, 32'h0);
      Stall = 1'b0;
      UartRxValid = 1'b0;
      idle();
      tick();

      // Status register read
      UartRxValid = 1'b1;
      UartTxReady = 1'b0;
      applyStimulus(32'h8000_0000, 32'h0, 4'b0000, 2'b10, 1'b0, 1'b1, 1'b0);
      tick();
      idle();
      checkOutput("uart_status", LoadData, 32'h00000002);
      UartRxValid = 1'b0;

      // Reset while a tx strobe is about to be issued
      UartTxReady = 1'b1;
      applyStimulus(32'h8000_0008, 32'h0000_0033, 4'b1000, 2'b00, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      tick();
      checkOutput("reset_drops_tx", {31'b0, UartTxValid}, 32'h0);
      idle();
      rst = 1'b0;

      // Ten cycles after reset, three of them retiring
      for (int i = 0; i < 10; i++) begin
         InstRetired = (i < 3);
         tick();
      end
      InstRetired = 1'b0;
      applyStimulus(32'h8000_0010, 32'h0, 4'b0000, 2'b10, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("cycle_count", LoadData, 32'd10);
      applyStimulus(32'h8000_0014, 32'h0, 4'b0000, 2'b10, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("instret_count", LoadData, 32'd3);

      // Clear store beats a same-cycle retirement
      InstRetired = 1'b1;
      applyStimulus(32'h8000_0018, 32'h0, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b1);
      tick();
      InstRetired = 1'b0;
      applyStimulus(32'h8000_0010, 32'h0, 4'b0000, 2'b10, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("cycle_cleared", LoadData, 32'd0);
      applyStimulus(32'h8000_0014, 32'h0, 4'b0000, 2'b10, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("instret_cleared", LoadData, 32'd0);

      // Preload the cycle counter to its maximum and watch it wrap
      dut.r_cycleCount <= 32'hFFFF_FFFF;
      applyStimulus(32'h8000_0010, 32'h0, 4'b0000, 2'b10, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("cycle_max", LoadData, 32'hFFFF_FFFF);
      applyStimulus(32'h8000_0010, 32'h0, 4'b0000, 2'b10, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("cycle_wrapped", LoadData, 32'h0);

      // Load, then stall three cycles while the BRAM output drifts
      DmemDout = 32'hAAAA_5555;
      applyStimulus(32'h1000_0000, 32'h0, 4'b0000, 2'b10, 1'b0, 1'b1, 1'b0);
      tick();
      Stall = 1'b1;
      idle();
      checkOutput("stall_first", LoadData, 32'hAAAA_5555);
      tick();
      DmemDout = 32'h1111_1111;
      #1;
      checkOutput("stall_second", LoadData, 32'hAAAA_5555);
      tick();
      DmemDout = 32'h2222_2222;
      #1;
      checkOutput("stall_third", LoadData, 32'hAAAA_5555);
      Stall = 1'b0;
      #1;
      checkOutput("stall_released", LoadData, 32'h2222_2222);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
